// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle: held byte/valid with ack, plus one-cycle error pulses.
interface uart_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       ack;
    logic       frame_error;
    logic       overrun;

    modport master (output data, output valid, output frame_error, output overrun, input ack);
    modport slave  (input data, input valid, input frame_error, input overrun, output ack);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, runtime bit period shared with the transmitter.
// Bytes are held on valid/ack; framing error and overrun are single-cycle pulses.
module uart_rx #(
    parameter int unsigned COUNTER_WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     uart_rx_in,
    input  logic [COUNTER_WIDTH-1:0] cycles_per_bit,
    uart_rx_if.master                bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e                   state_q;
    logic                     sync1_q;
    logic                     sync2_q;
    logic                     rx_d_q;
    logic [COUNTER_WIDTH-1:0] cnt_q;
    logic [2:0]               idx_q;
    logic [7:0]               shift_q;
    logic [7:0]               data_q;
    logic                     valid_q;
    logic                     frame_error_q;
    logic                     overrun_q;

    logic                     rx_s;
    logic [COUNTER_WIDTH-1:0] half;

    assign rx_s = sync2_q;
    assign half = cycles_per_bit >> 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            rx_d_q        <= 1'b1;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            sync1_q       <= uart_rx_in;
            sync2_q       <= sync1_q;
            rx_d_q        <= rx_s;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;

            // A good stop sample later in this block overrides this clear.
            if (bus.ack) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    if (rx_d_q && !rx_s) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (cnt_q == half) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + COUNTER_WIDTH'(1);
                    end
                end
                DATA: begin
                    if (cnt_q >= cycles_per_bit) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + COUNTER_WIDTH'(1);
                    end
                end
                STOP: begin
                    if (cnt_q >= cycles_per_bit) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        if (rx_s) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            if (valid_q && !bus.ack) begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frame_error_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + COUNTER_WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.data        = data_q;
    assign bus.valid       = valid_q;
    assign bus.frame_error = frame_error_q;
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// checked against a frame-level model of the receiver's visible behaviour.
module tb_uart_rx;

    logic        clk;
    logic        rst;
    logic        line;
    logic [23:0] cpb;

    int n_checks;
    int n_errors;
    int ferr_cnt;
    int ovr_cnt;

    uart_rx_if bus ();

    uart_rx #(.COUNTER_WIDTH(24)) dut (
        .clk           (clk),
        .rst           (rst),
        .uart_rx_in    (line),
        .cycles_per_bit(cpb),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters; a pulse wider than one cycle is counted more than once.
    always @(negedge clk) begin
        if (bus.frame_error === 1'b1) ferr_cnt++;
        if (bus.overrun === 1'b1) ovr_cnt++;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Stop-sample cycle, counted in clocks from the edge after which the start bit is driven:
    // 3 clocks to enter START, then half + 9 bit periods.
    function automatic int stop_cycle(input int cpb_v);
        return 3 + (cpb_v >> 1) + 9 * (cpb_v + 1);
    endfunction

    // Drives one 8N1 frame plus 'gap' idle cycles; optional ack pulse at cycle ack_at.
    // Returns valid just before and just after the stop-sample edge, and data after it.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int cpb_v,
                              input int gap, input int ack_at,
                              output logic v_s, output logic v_s1, output logic [7:0] d_s1);
        logic [9:0] fr;
        int         s;
        int         bi;
        fr   = {stop_bit, b, 1'b0};
        s    = stop_cycle(cpb_v);
        v_s  = 1'bx;
        v_s1 = 1'bx;
        d_s1 = 8'hxx;
        for (int c = 0; c < 10 * (cpb_v + 1) + gap; c++) begin
            if (c == s) v_s = bus.valid;
            if (c == s + 1) begin
                v_s1 = bus.valid;
                d_s1 = bus.data;
            end
            bi      = c / (cpb_v + 1);
            line    = (bi < 10) ? fr[bi] : 1'b1;
            bus.ack = (c == ack_at);
            tick(1);
        end
        bus.ack = 1'b0;
    endtask

    task automatic ack_pulse();
        bus.ack = 1'b1;
        tick(1);
        bus.ack = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        line    = 1'b1;
        bus.ack = 1'b0;
        cpb     = 24'd9;
        tick(3);
        n_checks++;
        if (bus.data !== 8'h00 || bus.valid !== 1'b0 || bus.frame_error !== 1'b0 || bus.overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got data=%h valid=%b ferr=%b ovr=%b, want 00 0 0 0",
                     bus.data, bus.valid, bus.frame_error, bus.overrun);
        end
        rst = 1'b0;
        tick(5);
    endtask

    task automatic test_basic();
        logic v_s, v_s1;
        logic [7:0] d;
        int f0, o0;
        f0  = ferr_cnt;
        o0  = ovr_cnt;
        cpb = 24'd9;
        send_frame(8'hA5, 1'b1, 9, 6, -1, v_s, v_s1, d);
        n_checks++;
        if (v_s !== 1'b0 || v_s1 !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_timing: valid before/after stop edge got %b/%b, want 0/1", v_s, v_s1);
        end
        n_checks++;
        if (d !== 8'hA5 || bus.data !== 8'hA5 || bus.valid !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_data: got %h/%h valid=%b, want a5 valid=1", d, bus.data, bus.valid);
        end
        n_checks++;
        if (ferr_cnt - f0 != 0 || ovr_cnt - o0 != 0) begin
            n_errors++;
            $display("FAIL basic_flags: got ferr=%0d ovr=%0d, want 0 0", ferr_cnt - f0, ovr_cnt - o0);
        end
        ack_pulse();
        n_checks++;
        if (bus.valid !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_ack: valid got %b, want 0", bus.valid);
        end
    endtask

    task automatic test_frame_error();
        logic v_s, v_s1;
        logic [7:0] d;
        int f0;
        f0  = ferr_cnt;
        cpb = 24'd9;
        send_frame(8'h3C, 1'b0, 9, 0, -1, v_s, v_s1, d);
        n_checks++;
        if (ferr_cnt - f0 != 1 || v_s1 !== 1'b0 || d !== 8'hA5) begin
            n_errors++;
            $display("FAIL ferr_pulse: got ferr=%0d valid=%b data=%h, want 1 0 a5", ferr_cnt - f0, v_s1, d);
        end
        line = 1'b0;
        tick(30 * 10);
        line = 1'b1;
        tick(20);
        n_checks++;
        if (ferr_cnt - f0 != 1) begin
            n_errors++;
            $display("FAIL break_single: ferr pulses got %0d, want 1", ferr_cnt - f0);
        end
        n_checks++;
        if (bus.valid !== 1'b0 || bus.data !== 8'hA5) begin
            n_errors++;
            $display("FAIL break_hold: got valid=%b data=%h, want 0 a5", bus.valid, bus.data);
        end
    endtask

    task automatic test_glitch();
        logic v_s, v_s1;
        logic [7:0] d;
        int f0;
        f0   = ferr_cnt;
        cpb  = 24'd9;
        line = 1'b0;
        tick(3);
        line = 1'b1;
        tick(30);
        n_checks++;
        if (bus.valid !== 1'b0 || ferr_cnt - f0 != 0) begin
            n_errors++;
            $display("FAIL glitch_reject: got valid=%b ferr=%0d, want 0 0", bus.valid, ferr_cnt - f0);
        end
        send_frame(8'h3C, 1'b1, 9, 6, -1, v_s, v_s1, d);
        n_checks++;
        if (d !== 8'h3C || v_s1 !== 1'b1 || ferr_cnt - f0 != 0) begin
            n_errors++;
            $display("FAIL glitch_after: got data=%h valid=%b ferr=%0d, want 3c 1 0", d, v_s1, ferr_cnt - f0);
        end
        ack_pulse();
    endtask

    task automatic test_back_to_back();
        logic v_s, v_s1;
        logic [7:0] d;
        int o0;
        cpb = 24'd9;
        o0  = ovr_cnt;
        send_frame(8'h11, 1'b1, 9, 0, -1, v_s, v_s1, d);
        send_frame(8'h22, 1'b1, 9, 4, -1, v_s, v_s1, d);
        n_checks++;
        if (bus.data !== 8'h22 || bus.valid !== 1'b1 || ovr_cnt - o0 != 1) begin
            n_errors++;
            $display("FAIL overrun: got data=%h valid=%b ovr=%0d, want 22 1 1", bus.data, bus.valid, ovr_cnt - o0);
        end
        ack_pulse();
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b1, 9, 0, -1, v_s, v_s1, d);
        send_frame(8'h22, 1'b1, 9, 4, stop_cycle(9), v_s, v_s1, d);
        n_checks++;
        if (v_s1 !== 1'b1 || d !== 8'h22 || ovr_cnt - o0 != 0) begin
            n_errors++;
            $display("FAIL set_wins: got valid=%b data=%h ovr=%0d, want 1 22 0", v_s1, d, ovr_cnt - o0);
        end
        ack_pulse();
    endtask

    task automatic test_reset_midframe();
        logic v_s, v_s1;
        logic [7:0] d;
        logic [9:0] fr;
        cpb = 24'd9;
        send_frame(8'h5A, 1'b1, 9, 6, -1, v_s, v_s1, d);
        fr = {1'b1, 8'hFF, 1'b0};
        for (int c = 0; c < 5 * 10 + 5; c++) begin
            line = fr[c / 10];
            tick(1);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.data !== 8'h00 || bus.valid !== 1'b0 || bus.frame_error !== 1'b0 || bus.overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_async: got data=%h valid=%b ferr=%b ovr=%b, want 00 0 0 0",
                     bus.data, bus.valid, bus.frame_error, bus.overrun);
        end
        line = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(5);
        send_frame(8'h7E, 1'b1, 9, 6, -1, v_s, v_s1, d);
        n_checks++;
        if (d !== 8'h7E || v_s1 !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_recover: got data=%h valid=%b, want 7e 1", d, v_s1);
        end
    endtask

    task automatic test_loopback();
        logic v_s, v_s1;
        logic [7:0] d;
        logic [7:0] bytes [4];
        int f0, o0;
        bytes = '{8'h00, 8'hFF, 8'h55, 8'h80};
        ack_pulse();
        f0  = ferr_cnt;
        o0  = ovr_cnt;
        cpb = 24'd433;
        for (int i = 0; i < 4; i++) begin
            send_frame(bytes[i], 1'b1, 433, 0, stop_cycle(433) + 1, v_s, v_s1, d);
            n_checks++;
            if (d !== bytes[i] || v_s1 !== 1'b1) begin
                n_errors++;
                $display("FAIL loopback_%0d: got data=%h valid=%b, want %h 1", i, d, v_s1, bytes[i]);
            end
        end
        tick(10);
        n_checks++;
        if (ferr_cnt - f0 != 0 || ovr_cnt - o0 != 0) begin
            n_errors++;
            $display("FAIL loopback_flags: got ferr=%0d ovr=%0d, want 0 0", ferr_cnt - f0, ovr_cnt - o0);
        end
    endtask

    // Frame-level model: good frames latch the byte, bad ones only pulse frame_error.
    task automatic test_random();
        logic v_s, v_s1;
        logic [7:0] d;
        logic [7:0] b;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       stop_bit;
        int         exp_ferr, exp_ovr, f0, o0, cpb_v, mode;
        exp_data  = 8'h80;
        exp_valid = 1'b0;
        exp_ferr  = 0;
        exp_ovr   = 0;
        f0        = ferr_cnt;
        o0        = ovr_cnt;
        for (int i = 0; i < 16; i++) begin
            cpb_v    = int'($urandom_range(3, 20));
            b        = 8'($urandom);
            stop_bit = ($urandom_range(0, 3) != 0);
            mode     = int'($urandom_range(0, 2));
            cpb      = 24'(cpb_v);
            send_frame(b, stop_bit, cpb_v, 6, (mode == 1) ? stop_cycle(cpb_v) : -1, v_s, v_s1, d);
            if (stop_bit) begin
                if (exp_valid && mode != 1) exp_ovr++;
                exp_valid = 1'b1;
                exp_data  = b;
            end else begin
                exp_ferr++;
                if (mode == 1) exp_valid = 1'b0;
            end
            n_checks++;
            if (bus.data !== exp_data || bus.valid !== exp_valid ||
                ferr_cnt - f0 != exp_ferr || ovr_cnt - o0 != exp_ovr) begin
                n_errors++;
                $display("FAIL random_%0d: got data=%h valid=%b ferr=%0d ovr=%0d, want %h %b %0d %0d",
                         i, bus.data, bus.valid, ferr_cnt - f0, ovr_cnt - o0,
                         exp_data, exp_valid, exp_ferr, exp_ovr);
            end
            if (mode == 2) begin
                ack_pulse();
                exp_valid = 1'b0;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        ferr_cnt = 0;
        ovr_cnt  = 0;
        bus.ack  = 1'b0;
        line     = 1'b1;
        rst      = 1'b1;
        cpb      = 24'd9;
        test_reset();
        test_basic();
        test_frame_error();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        test_loopback();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver, 8N1, LSB first, idle-high line. It is the receive half of the processor's programming/console UART and pairs with the existing transmitter. It shares the same runtime `cycles_per_bit` baud setting, so both directions run at one programmed rate. Received bytes are presented on a held `valid`/`ack` interface to the loader/bus side, with one-cycle framing-error and overrun flags.

## Interface
- `COUNTER_WIDTH`, default 24: width of the bit-period counter and of `cycles_per_bit`.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `uart_rx_in`  in  1: asynchronous serial line, idle high.
- `cycles_per_bit`  in  COUNTER_WIDTH: bit period minus one, in `clk` cycles. One bit = `cycles_per_bit`+1 clocks, the same definition the transmitter uses. Must be static during a frame.
- `data`  out  8: last good received byte; held until the next good frame.
- `valid`  out  1: a byte is available in `data`; held until acknowledged.
- `ack`  in  1: consumer has taken `data`; clears `valid`.
- `frame_error`  out  1: one-cycle pulse when a stop bit samples 0.
- `overrun`  out  1: one-cycle pulse when a good frame completes while `valid` is still 1.

## Operation
- Synchronizer: two flops on `uart_rx_in`, both reset to 1. All logic uses the synchronized value `rx_s`. A registered copy `rx_d` is kept for edge detection.
- Half period: `half` = `cycles_per_bit` >> 1, using truncating shift.
- Bit counter: COUNTER_WIDTH bits. It is zeroed in IDLE and on every sample point, and increments by 1 otherwise. It never wraps within a legal frame.
- FSM states: IDLE, START, DATA, STOP. A 3-bit index counts data bits 0..7.
  - IDLE: on a falling edge (`rx_d`=1, `rx_s`=0), go to START with the counter at 0. A line that is merely low does not start a frame. This makes a break condition yield exactly one frame.
  - START: when counter == `half`, check `rx_s`.
    - If `rx_s`=0: go to DATA with index 0 and counter 0.
    - If `rx_s`=1: treat as a glitch and return to IDLE. No flags are raised.
  - DATA: when counter >= `cycles_per_bit`, shift `rx_s` into bit 7 of the shift register, shifting right. After the sample with index 7, go to STOP. Otherwise increment the index.
  - STOP: when counter >= `cycles_per_bit`, sample `rx_s` and go to IDLE in the same cycle. This permits back-to-back frames from mid-stop-bit.
    - If 1: load `data` from the shift register and set `valid`. If `valid` was already 1 and `ack` is not asserted this cycle, also pulse `overrun`.
    - If 0: pulse `frame_error`. `data` and `valid` are unchanged.
- Illegal or unused state encodings go to IDLE on the next clock.
- `ack` clears `valid` on the next edge. Setting wins over clearing: if a good stop sample and `ack` occur in the same cycle, `valid` stays 1, `data` takes the new byte, and no overrun is raised.
- `ack` while `valid`=0 is ignored.

## Timing
- Reset values: `data`=0x00, `valid`=0, `frame_error`=0, `overrun`=0, FSM=IDLE, counter=0, index=0, synchronizer flops=1.
- Reset takes effect immediately, asynchronously, including mid-frame. The first frame after reset is received normally once a falling edge is seen.
- Pin-to-detect latency: 2 clocks through the synchronizer, plus 1 clock to register the edge into START.
- Sample points, measured from START entry:
  - Start-bit check at `half` cycles.
  - Data bit i sampled (`half`+1) + (i+1)·(`cycles_per_bit`+1) − 1 cycles after START entry.
  - Stop bit sampled one bit period after bit 7.
- `valid`, `data`, `frame_error` and `overrun` are all registered. They update on the clock edge that ends the stop-sample cycle.
- Pulses (`frame_error`, `overrun`) are exactly 1 cycle wide.
- Supported range: `cycles_per_bit` >= 3. Smaller values produce unspecified data, but the FSM must never lock up.

## Test plan
- Basic receive: `cycles_per_bit`=9, drive 0xA5 as 8N1. Required: `data`=0xA5 and `valid`=1 after the stop sample, no flags. Then pulse `ack` for 1 cycle; `valid`=0 on the next edge.
- Glitch rejection: `cycles_per_bit`=9, line low for 3 clocks, then high. Required: FSM back in IDLE, `valid`=0, no `frame_error`. A subsequent 0x3C frame is received correctly.
- Framing error and break: send 0x3C with the stop bit driven 0. Required: one `frame_error` pulse, `valid`=0, `data` unchanged. Then hold the line low for 30 bit times: no additional `frame_error`.
- Overrun and set-wins: send 0x11 then 0x22 back-to-back without `ack`. Required: `data`=0x22, `valid`=1, one `overrun` pulse. Repeat with `ack` coincident with the second stop sample: `valid`=1 and no `overrun`.
- Reset mid-frame: assert `rst` during data bit 4 of 0xFF. Required: all outputs at reset values immediately, with no clock edge needed. After release, 0x7E is received correctly.
- Loopback: connect the transmitter output to `uart_rx_in`, `cycles_per_bit`=433, send 0x00, 0xFF, 0x55 and 0x80 back-to-back. Required: each byte is received in order with no flags.
